// File: rtl/melody_player.sv
// melody_player: plays a writable table of {half-period, duration} notes as a square wave,
// with octave shift, rests, an inter-note gap and one-shot or loop sequencing.
module melody_player #(
    parameter int DIV_W      = 20,
    parameter int DUR_W      = 32,
    parameter int ADDR_W     = 5,
    parameter int GAP_CYCLES = 2_500_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              play,
    input  logic              mode_loop,
    input  logic [1:0]        octave,
    input  logic [ADDR_W:0]   seq_len,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DIV_W-1:0]  wr_half,
    input  logic [DUR_W-1:0]  wr_dur,
    output logic              melody,
    output logic              busy,
    output logic [ADDR_W-1:0] note_idx,
    output logic              done
);
    localparam int HW = DIV_W + 3;
    localparam int LW = ADDR_W + 1;
    localparam logic [LW-1:0] DEPTH = LW'(2 ** ADDR_W);

    typedef enum logic [2:0] {IDLE, LOAD, TONE, GAP, NEXT} state_t;
    state_t state, state_d;

    logic                     play_q, start_q, rest, last, expire, gap_end, hit;
    logic [HW-1:0]            half_eff, half_cnt;
    logic [DUR_W-1:0]         dur_eff, dur_cnt;
    logic [31:0]              gap_cnt;
    logic [LW-1:0]            len_c, len_q;
    logic [ADDR_W-1:0]        idx, idx_d;
    logic [DIV_W+DUR_W-1:0]   mem [2**ADDR_W];
    logic [DIV_W+DUR_W-1:0]   rd_q;
    logic [DIV_W-1:0]         rd_half;
    logic [DUR_W-1:0]         rd_dur;

    assign {rd_half, rd_dur} = rd_q;
    assign len_c   = seq_len > DEPTH ? DEPTH : seq_len;
    assign last    = {1'b0, idx} == len_q - LW'(1);
    assign expire  = dur_cnt == dur_eff - DUR_W'(1);
    assign gap_end = gap_cnt == 32'(GAP_CYCLES - 1);
    assign hit     = !rest && half_cnt == half_eff - HW'(1);

    // Read address tracks the index of the next cycle so LOAD sees its note already registered.
    always_comb begin
        idx_d = (!play || state == IDLE) ? '0 :
                (state == NEXT) ? (last ? '0 : idx + ADDR_W'(1)) : idx;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= {wr_half, wr_dur};
        rd_q <= (wr_en && wr_addr == idx_d) ? {wr_half, wr_dur} : mem[idx_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (state != IDLE && !play) state_d = IDLE;
        else
            case (state)
                IDLE:    state_d = (start_q && play && len_c != '0) ? LOAD : IDLE;
                LOAD:    state_d = TONE;
                TONE:    state_d = !expire ? TONE : (GAP_CYCLES == 0 ? NEXT : GAP);
                GAP:     state_d = gap_end ? NEXT : GAP;
                NEXT:    state_d = (!last || (mode_loop && len_c != '0)) ? LOAD : IDLE;
                default: state_d = IDLE;
            endcase
    end

    always_comb begin
        busy     = state != IDLE;
        note_idx = idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            play_q   <= 1'b0;
            start_q  <= 1'b0;
            idx      <= '0;
            len_q    <= '0;
            half_eff <= '0;
            dur_eff  <= '0;
            rest     <= 1'b0;
            half_cnt <= '0;
            dur_cnt  <= '0;
            gap_cnt  <= '0;
            melody   <= 1'b0;
            done     <= 1'b0;
        end else begin
            play_q  <= play;
            start_q <= play & ~play_q;
            idx     <= idx_d;
            if (state == IDLE || (state == NEXT && last)) len_q <= len_c;
            if (state == LOAD) begin
                half_eff <= {3'b000, rd_half} << octave;
                dur_eff  <= rd_dur == '0 ? DUR_W'(1) : rd_dur;
                rest     <= rd_half == '0;
            end
            half_cnt <= (state != TONE || hit) ? '0 : half_cnt + HW'(1);
            dur_cnt  <= state == TONE ? dur_cnt + DUR_W'(1) : '0;
            gap_cnt  <= state == GAP ? gap_cnt + 32'd1 : '0;
            // Expiry beats a coincident toggle because leaving TONE forces the output low.
            melody   <= state_d != TONE ? 1'b0 : (state == TONE && hit) ? ~melody : melody;
            done     <= state == NEXT && play && last && !mode_loop;
        end
    end
endmodule

// File: tb/tb_melody_player.sv
// tb_melody_player: table-driven and randomized checks of melody_player against a timeline model.
module tb_melody_player;
    localparam int DIV_W = 20, DUR_W = 32, ADDR_W = 3, GAP = 4, DEPTH = 8;

    logic              clk = 0, rst_n = 0, play = 0, mode_loop = 0, wr_en = 0;
    logic [1:0]        octave = 0;
    logic [ADDR_W:0]   seq_len = 0;
    logic [ADDR_W-1:0] wr_addr = 0;
    logic [DIV_W-1:0]  wr_half = 0;
    logic [DUR_W-1:0]  wr_dur = 0;
    logic              melody, busy, done;
    logic [ADDR_W-1:0] note_idx;

    melody_player #(.DIV_W(DIV_W), .DUR_W(DUR_W), .ADDR_W(ADDR_W), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .play(play), .mode_loop(mode_loop), .octave(octave),
        .seq_len(seq_len), .wr_en(wr_en), .wr_addr(wr_addr), .wr_half(wr_half), .wr_dur(wr_dur),
        .melody(melody), .busy(busy), .note_idx(note_idx), .done(done)
    );

    always #5 clk = ~clk;

    int     vectors = 0, miscompares = 0;
    int     mh[DEPTH];
    longint md[DEPTH];

    typedef struct {
        int half; int dur; int oct; int exp_first; int exp_hi; int exp_busy;
    } row_t;

    row_t tbl[9] = '{
        '{3, 20, 0, 3, 9, 26},
        '{3, 20, 2, 12, 8, 26},
        '{3, 0, 0, -1, 0, 7},
        '{2, 10, 0, 2, 4, 16},
        '{0, 10, 0, -1, 0, 16},
        '{1, 6, 0, 1, 3, 12},
        '{3, 6, 0, 3, 3, 12},
        '{524290, 40, 1, -1, 0, 46},
        '{1048575, 30, 3, -1, 0, 36}
    };

    task automatic check(input string name, input longint got, input longint exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic wr(input int a, input int h, input longint d);
        wr_en = 1; wr_addr = ADDR_W'(a); wr_half = DIV_W'(h); wr_dur = DUR_W'(d);
        mh[a] = h; md[a] = d;
        @(negedge clk);
        wr_en = 0;
        @(negedge clk);
    endtask

    // Expected per-cycle timeline from LOAD onwards: LOAD, dur_eff TONE cycles, GAP, NEXT per note.
    task automatic run_prog(input int n_req, input int oct, input int wr_at,
                            output int busy_cnt, output int first_hi, output int hi_cnt, output int done_t);
        int     n;
        bit     eb[$], em[$], ed[$];
        int     ei[$];
        longint h, d;
        n = n_req > DEPTH ? DEPTH : n_req;
        for (int i = 0; i < n; i++) begin
            h = longint'(mh[i]) << oct;
            d = md[i] == 0 ? 1 : md[i];
            eb.push_back(1); em.push_back(0); ed.push_back(0); ei.push_back(i);
            for (longint j = 0; j < d; j++) begin
                eb.push_back(1); em.push_back(mh[i] != 0 && (j / h) % 2 == 1); ed.push_back(0); ei.push_back(i);
            end
            for (int j = 0; j < GAP + 1; j++) begin
                eb.push_back(1); em.push_back(0); ed.push_back(0); ei.push_back(i);
            end
        end
        eb.push_back(0); em.push_back(0); ed.push_back(1); ei.push_back(0);
        eb.push_back(0); em.push_back(0); ed.push_back(0); ei.push_back(0);
        busy_cnt = 0; first_hi = -1; hi_cnt = 0; done_t = -1;
        octave = 2'(oct); seq_len = 4'(n_req); mode_loop = 0; play = 1;
        @(negedge clk);
        check("pre_load_busy", busy, 0);
        foreach (eb[k]) begin
            if (k == wr_at) begin
                wr_en = 1; wr_addr = 0; wr_half = 1; wr_dur = 50;
            end else wr_en = 0;
            @(negedge clk);
            check("busy", busy, eb[k]);
            check("melody", melody, em[k]);
            check("done", done, ed[k]);
            if (eb[k]) check("note_idx", note_idx, ei[k]);
            if (busy) busy_cnt++;
            if (melody) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = k - 1;
            end
            if (done) done_t = k;
        end
        wr_en = 0; play = 0;
        @(negedge clk);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int b, f, hc, dn, wt, prev, changes, bad, dsum, lastidx;
        #12;
        check("rst_melody", melody, 0); check("rst_busy", busy, 0);
        check("rst_idx", note_idx, 0); check("rst_done", done, 0);
        @(negedge clk); rst_n = 1;
        @(negedge clk);

        foreach (tbl[r]) begin
            wr(0, tbl[r].half, tbl[r].dur);
            run_prog(1, tbl[r].oct, -1, b, f, hc, dn);
            check("tbl_busy_cycles", b, tbl[r].exp_busy);
            check("tbl_first_toggle", f, tbl[r].exp_first);
            check("tbl_high_cycles", hc, tbl[r].exp_hi);
            check("tbl_done_time", dn, tbl[r].exp_busy);
        end

        wr(0, 3, 12); wr(1, 0, 8); wr(2, 5, 10);
        run_prog(3, 0, -1, b, f, hc, dn);
        check("three_busy", b, 48); check("three_high", hc, 11); check("three_done", dn, 48);

        wr(0, 3, 20);
        run_prog(1, 0, 5, b, f, hc, dn);
        mh[0] = 1; md[0] = 50;
        check("wr_tone_busy", b, 26); check("wr_tone_high", hc, 9);

        wr(0, 2, 5); wr(1, 3, 6);
        seq_len = 2; mode_loop = 1; octave = 0; play = 1;
        prev = 0; changes = 0; bad = 0; dsum = 0;
        repeat (80) begin
            @(negedge clk);
            if (busy && note_idx != ADDR_W'(prev)) begin
                changes++;
                if (int'(note_idx) != 1 - prev) bad++;
                prev = note_idx;
            end
            dsum += done;
        end
        check("loop_changes", changes, 6); check("loop_order", bad, 0); check("loop_done", dsum, 0);
        wt = 0;
        while (note_idx != 1 && wt < 30) begin @(negedge clk); wt++; end
        check("loop_reach_idx1", note_idx, 1);
        mode_loop = 0; lastidx = note_idx; wt = 0;
        while (!done && wt < 60) begin
            @(negedge clk);
            if (busy) lastidx = note_idx;
            wt++;
        end
        check("stop_done", done, 1); check("stop_last_idx", lastidx, 1);
        @(negedge clk);
        check("stop_busy", busy, 0);
        play = 0; @(negedge clk);

        wr(0, 3, 12); wr(1, 3, 100);
        seq_len = 2; play = 1;
        repeat (27) @(negedge clk);
        check("abort_pre_idx", note_idx, 1); check("abort_pre_busy", busy, 1);
        play = 0;
        @(negedge clk);
        check("abort_busy", busy, 0); check("abort_melody", melody, 0);
        check("abort_idx", note_idx, 0); check("abort_done", done, 0);
        dsum = 0;
        repeat (5) begin @(negedge clk); dsum += done + busy; end
        check("abort_quiet", dsum, 0);

        wr(0, 3, 2);
        seq_len = 1; play = 1; wt = 0;
        while (!done && wt < 40) begin @(negedge clk); wt++; end
        check("hold_done", done, 1);
        dsum = 0;
        repeat (30) begin @(negedge clk); dsum += busy + done; end
        check("hold_norestart", dsum, 0);
        play = 0; @(negedge clk);

        wr(0, 3, 20);
        seq_len = 1; play = 1; wt = 0;
        while (!melody && wt < 30) begin @(negedge clk); wt++; end
        check("arst_pre_melody", melody, 1);
        #1 rst_n = 0;
        #1;
        check("arst_melody", melody, 0); check("arst_busy", busy, 0);
        check("arst_idx", note_idx, 0); check("arst_done", done, 0);
        play = 0;
        @(negedge clk); rst_n = 1;
        @(negedge clk);

        seq_len = 0; play = 1; dsum = 0;
        repeat (10) begin @(negedge clk); dsum += busy; end
        check("seq0_busy", dsum, 0);
        play = 0; @(negedge clk);

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < DEPTH; i++) wr(i, $urandom_range(0, 5), $urandom_range(0, 12));
            run_prog($urandom_range(1, 12), $urandom_range(0, 2), -1, b, f, hc, dn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
